// File: rtl/ws2812_frame_ctrl.sv
// WS2812 frame sequencer: fetches GRB words, hands them to a bit driver, then holds the latch gap.
// Optional per-frame brightness scaling is enabled with `define WS2812_BRIGHTNESS_EN.
module ws2812_frame_ctrl #(
    parameter int NUM_LEDS     = 16,
    parameter int LATCH_CYCLES = 18200,
    parameter int AW           = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          frame_start,
    output logic          pix_rd,
    output logic [AW-1:0] pix_addr,
    input  logic [23:0]   pix_data,
    output logic [23:0]   grb_word,
    output logic          word_start,
    input  logic          word_done,
`ifdef WS2812_BRIGHTNESS_EN
    input  logic [7:0]    bright,
`endif
    output logic          busy,
    output logic          frame_done
);

    localparam int CW = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;
    localparam logic [AW-1:0] LAST_IDX   = AW'(NUM_LEDS - 1);
    localparam logic [CW-1:0] LATCH_INIT = CW'(LATCH_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        ARM,
        SEND,
        NEXT,
        LATCH
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [23:0]   grb_q, grb_d;
    logic          pix_rd_q, pix_rd_d;
    logic          word_start_q, word_start_d;
    logic          busy_q, busy_d;
    logic          frame_done_q, frame_done_d;
    logic [23:0]   load_word;

`ifdef WS2812_BRIGHTNESS_EN
    logic [7:0] bright_q, bright_d;

    function automatic logic [7:0] scale(input logic [7:0] chan, input logic [7:0] b);
        logic [15:0] prod;
        prod = chan * b;
        return prod[15:8];
    endfunction

    assign load_word = {scale(pix_data[23:16], bright_q),
                        scale(pix_data[15:8], bright_q),
                        scale(pix_data[7:0], bright_q)};
`else
    assign load_word = pix_data;
`endif

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        grb_d        = grb_q;
        pix_rd_d     = 1'b0;
        word_start_d = word_start_q;
        busy_d       = busy_q;
        frame_done_d = 1'b0;
`ifdef WS2812_BRIGHTNESS_EN
        bright_d     = bright_q;
`endif
        unique case (state_q)
            IDLE: begin
                // The frame_done cycle is still part of the finished frame.
                if (frame_start && word_done && !frame_done_q) begin
                    idx_d    = '0;
                    busy_d   = 1'b1;
                    pix_rd_d = 1'b1;
                    state_d  = FETCH;
`ifdef WS2812_BRIGHTNESS_EN
                    bright_d = bright;
`endif
                end
            end
            FETCH: state_d = LOAD;
            LOAD: begin
                grb_d        = load_word;
                word_start_d = 1'b1;
                state_d      = ARM;
            end
            ARM: begin
                if (!word_done) begin
                    word_start_d = 1'b0;
                    state_d      = SEND;
                end
            end
            SEND: begin
                if (word_done) state_d = NEXT;
            end
            NEXT: begin
                if (idx_q == LAST_IDX) begin
                    cnt_d   = LATCH_INIT;
                    state_d = LATCH;
                end else begin
                    idx_d    = idx_q + AW'(1);
                    pix_rd_d = 1'b1;
                    state_d  = FETCH;
                end
            end
            LATCH: begin
                if (cnt_q == '0) begin
                    frame_done_d = 1'b1;
                    busy_d       = 1'b0;
                    state_d      = IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            grb_q        <= '0;
            pix_rd_q     <= 1'b0;
            word_start_q <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
`ifdef WS2812_BRIGHTNESS_EN
            bright_q     <= '0;
`endif
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            grb_q        <= grb_d;
            pix_rd_q     <= pix_rd_d;
            word_start_q <= word_start_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
`ifdef WS2812_BRIGHTNESS_EN
            bright_q     <= bright_d;
`endif
        end
    end

    assign pix_rd     = pix_rd_q;
    assign pix_addr   = idx_q;
    assign grb_word   = grb_q;
    assign word_start = word_start_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_ws2812_frame_ctrl.sv
// Directed bench for ws2812_frame_ctrl: 3-LED and 1-LED chains with a bit-driver model.
// Brightness check runs only when WS2812_BRIGHTNESS_EN is defined.
module tb_ws2812_frame_ctrl;

    localparam int LATCH = 50;
    localparam int WT    = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fs   [2];
    logic        pr   [2];
    logic [3:0]  pa   [2];
    logic [23:0] pd   [2];
    logic [23:0] grb  [2];
    logic        ws   [2];
    logic        wd   [2];
    logic        busy [2];
    logic        fd   [2];
`ifdef WS2812_BRIGHTNESS_EN
    logic [7:0]  br = 8'hFF;
`endif

    int          cyc = 0;
    int          fall [2];
    logic [23:0] u1_val;

    logic        act     [2];
    int          dc      [2];
    logic [23:0] cur     [2];
    logic [23:0] wlog    [2][8];
    int          wcnt    [2];
    logic [3:0]  alog    [2][8];
    int          acnt    [2];
    logic        grb_bad [2];
    logic        lag_bad [2];
    logic        arm_seen[2];
    int          hi_run  [2];
    int          hi_max  [2];
    logic        pend    [2];
    int          rise_cyc[2];
    int          gap_max [2];
    int          fd_cnt  [2];

    int npass = 0;
    int ntot  = 0;

    always #5 clk = ~clk;

    ws2812_frame_ctrl #(.NUM_LEDS(3), .LATCH_CYCLES(LATCH), .AW(4)) u0 (
        .clk(clk), .rst(rst), .frame_start(fs[0]),
        .pix_rd(pr[0]), .pix_addr(pa[0]), .pix_data(pd[0]),
        .grb_word(grb[0]), .word_start(ws[0]), .word_done(wd[0]),
`ifdef WS2812_BRIGHTNESS_EN
        .bright(br),
`endif
        .busy(busy[0]), .frame_done(fd[0])
    );

    ws2812_frame_ctrl #(.NUM_LEDS(1), .LATCH_CYCLES(LATCH), .AW(4)) u1 (
        .clk(clk), .rst(rst), .frame_start(fs[1]),
        .pix_rd(pr[1]), .pix_addr(pa[1]), .pix_data(pd[1]),
        .grb_word(grb[1]), .word_start(ws[1]), .word_done(wd[1]),
`ifdef WS2812_BRIGHTNESS_EN
        .bright(br),
`endif
        .busy(busy[1]), .frame_done(fd[1])
    );

    function automatic logic [23:0] store(input int g, input logic [3:0] a);
        if (g == 1) return u1_val;
        case (a)
            4'd0:    return 24'h110000;
            4'd1:    return 24'h002200;
            4'd2:    return 24'h000033;
            default: return 24'hDEAD00;
        endcase
    endfunction

    function automatic logic [23:0] scale(input logic [23:0] v);
`ifdef WS2812_BRIGHTNESS_EN
        logic [15:0] r, g, b;
        r = v[23:16] * br;
        g = v[15:8] * br;
        b = v[7:0] * br;
        return {r[15:8], g[15:8], b[15:8]};
`else
        return v;
`endif
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Pixel store with one-cycle read latency plus a bit-driver model.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int g = 0; g < 2; g++) begin
                pd[g] <= '0; wd[g] <= 1'b1; act[g] <= 1'b0; dc[g] <= 0;
                cur[g] <= '0; wcnt[g] <= 0; acnt[g] <= 0;
                grb_bad[g] <= 1'b0; lag_bad[g] <= 1'b0; arm_seen[g] <= 1'b0;
                hi_run[g] <= 0; hi_max[g] <= 0; pend[g] <= 1'b0;
                rise_cyc[g] <= 0; gap_max[g] <= 0; fd_cnt[g] <= 0;
            end
        end else begin
            for (int g = 0; g < 2; g++) begin
                if (pr[g]) begin
                    pd[g] <= store(g, pa[g]);
                    if (acnt[g] < 8) alog[g][acnt[g]] <= pa[g];
                    acnt[g] <= acnt[g] + 1;
                end
                if (!act[g]) begin
                    if (ws[g] && wd[g]) begin
                        act[g] <= 1'b1;
                        dc[g]  <= 0;
                        cur[g] <= grb[g];
                        if (wcnt[g] < 8) wlog[g][wcnt[g]] <= grb[g];
                        wcnt[g] <= wcnt[g] + 1;
                        if (pend[g]) begin
                            pend[g] <= 1'b0;
                            if (cyc - rise_cyc[g] > gap_max[g]) gap_max[g] <= cyc - rise_cyc[g];
                        end
                    end
                end else begin
                    dc[g] <= dc[g] + 1;
                    if (dc[g] + 1 == fall[g]) wd[g] <= 1'b0;
                    if (dc[g] + 1 == fall[g] + WT) begin
                        wd[g]       <= 1'b1;
                        act[g]      <= 1'b0;
                        rise_cyc[g] <= cyc;
                        pend[g]     <= 1'b1;
                    end
                    if (grb[g] !== cur[g]) grb_bad[g] <= 1'b1;
                end
                if (arm_seen[g] && ws[g]) lag_bad[g] <= 1'b1;
                arm_seen[g] <= ws[g] && !wd[g];
                if (ws[g]) begin
                    hi_run[g] <= hi_run[g] + 1;
                    if (hi_run[g] + 1 > hi_max[g]) hi_max[g] <= hi_run[g] + 1;
                end else begin
                    hi_run[g] <= 0;
                end
                if (fd[g]) begin
                    fd_cnt[g] <= fd_cnt[g] + 1;
                    pend[g]   <= 1'b0;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic pulse(input int g);
        @(negedge clk);
        fs[g] = 1'b1;
        @(negedge clk);
        fs[g] = 1'b0;
    endtask

    task automatic wait_fd(input int g, output int drops, output bit seen, output int at);
        drops = 0;
        seen  = 1'b0;
        at    = 0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (fd[g]) begin
                seen = 1'b1;
                at   = cyc - 1;
                break;
            end
            if (!busy[g]) drops++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int  drops;
        bit  seen;
        int  at;
        int  n;

        fs[0] = 1'b0; fs[1] = 1'b0;
        fall[0] = 1; fall[1] = 1;
        u1_val = 24'hABCDEF;
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy[0]}, 32'd0);
        chk("rst_pix_rd", {31'd0, pr[0]}, 32'd0);
        chk("rst_word_start", {31'd0, ws[0]}, 32'd0);
        chk("rst_frame_done", {31'd0, fd[0]}, 32'd0);
        chk("rst_grb", {8'd0, grb[0]}, 32'd0);
        chk("rst_addr", {28'd0, pa[0]}, 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Three-word frame with stray frame_start mid-frame and on frame_done.
        pulse(0);
        chk("accept_busy", {31'd0, busy[0]}, 32'd1);
        for (n = 0; n < 500 && acnt[0] < 2; n++) @(negedge clk);
        chk("mid_wait", {31'd0, acnt[0] >= 2}, 32'd1);
        fs[0] = 1'b1;
        @(negedge clk);
        fs[0] = 1'b0;
        wait_fd(0, drops, seen, at);
        chk("a_fd_seen", {31'd0, seen}, 32'd1);
        fs[0] = 1'b1;
        @(negedge clk);
        fs[0] = 1'b0;
        chk("a_busy_drop", drops, 32'd0);
        chk("a_fd_latency", at - rise_cyc[0], LATCH + 2);
        repeat (100) @(negedge clk);
        chk("a_words", wcnt[0], 32'd3);
        chk("a_word0", {8'd0, wlog[0][0]}, {8'd0, scale(24'h110000)});
        chk("a_word1", {8'd0, wlog[0][1]}, {8'd0, scale(24'h002200)});
        chk("a_word2", {8'd0, wlog[0][2]}, {8'd0, scale(24'h000033)});
        chk("a_reads", acnt[0], 32'd3);
        chk("a_addr0", {28'd0, alog[0][0]}, 32'd0);
        chk("a_addr1", {28'd0, alog[0][1]}, 32'd1);
        chk("a_addr2", {28'd0, alog[0][2]}, 32'd2);
        chk("a_fd_count", fd_cnt[0], 32'd1);
        chk("a_idle_busy", {31'd0, busy[0]}, 32'd0);
        chk("a_grb_stable", {31'd0, grb_bad[0]}, 32'd0);
        chk("a_word_gap", gap_max[0], 32'd5);
        chk("a_ws_drop", {31'd0, lag_bad[0]}, 32'd0);

        // Single-LED chain.
        pulse(1);
        wait_fd(1, drops, seen, at);
        chk("c_fd_seen", {31'd0, seen}, 32'd1);
        chk("c_busy_drop", drops, 32'd0);
        repeat (4) @(negedge clk);
        chk("c_words", wcnt[1], 32'd1);
        chk("c_word0", {8'd0, wlog[1][0]}, {8'd0, scale(24'hABCDEF)});
        chk("c_addr0", {28'd0, alog[1][0]}, 32'd0);
        chk("c_fd_count", fd_cnt[1], 32'd1);

        // Slow driver: word_done falls 7 clocks after start.
        do_reset();
        fall[0] = 7;
        pulse(0);
        wait_fd(0, drops, seen, at);
        chk("d_fd_seen", {31'd0, seen}, 32'd1);
        chk("d_words", wcnt[0], 32'd3);
        chk("d_ws_high", hi_max[0], 32'd9);
        chk("d_ws_drop", {31'd0, lag_bad[0]}, 32'd0);
        chk("d_grb_stable", {31'd0, grb_bad[0]}, 32'd0);
        chk("d_fd_latency", at - rise_cyc[0], LATCH + 2);

        // Asynchronous reset while word 1 is sending.
        do_reset();
        fall[0] = 1;
        pulse(0);
        for (n = 0; n < 500 && !(pa[0] == 4'd1 && !wd[0] && !ws[0]); n++) @(negedge clk);
        chk("b_send_wait", {31'd0, pa[0] == 4'd1 && !wd[0]}, 32'd1);
        #1 rst = 1'b0;
        #1;
        chk("b_busy", {31'd0, busy[0]}, 32'd0);
        chk("b_pix_rd", {31'd0, pr[0]}, 32'd0);
        chk("b_word_start", {31'd0, ws[0]}, 32'd0);
        chk("b_frame_done", {31'd0, fd[0]}, 32'd0);
        chk("b_grb", {8'd0, grb[0]}, 32'd0);
        chk("b_addr", {28'd0, pa[0]}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        pulse(0);
        for (n = 0; n < 200 && acnt[0] < 1; n++) @(negedge clk);
        chk("b_reads", {31'd0, acnt[0] >= 1}, 32'd1);
        chk("b_first_addr", {28'd0, alog[0][0]}, 32'd0);
        wait_fd(0, drops, seen, at);
        chk("b_fd_seen", {31'd0, seen}, 32'd1);

`ifdef WS2812_BRIGHTNESS_EN
        do_reset();
        u1_val = 24'hFF8040;
        br = 8'h80;
        pulse(1);
        wait_fd(1, drops, seen, at);
        chk("e_fd_seen", {31'd0, seen}, 32'd1);
        chk("e_bright_word", {8'd0, wlog[1][0]}, 32'h007F4020);
`endif

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
